fractal_sync_1d_rf_req_ctrl: RTL and testbench
==============================================

FRACTAL_SYNC_1D_RF_REQ_CTRL -- requirements
Module: fractal_sync_1d_rf_req_ctrl

Interface
REQ-001 Parameter LEVEL_WIDTH, default 1, width of the request level field.
REQ-002 Parameter ID_WIDTH, default 1, width of the barrier id.
REQ-003 Parameter SD_WIDTH, default 2, width of the src/dst field.
REQ-004 Parameter FIFO_DEPTH, default 4, bypass FIFO entries; power of two, >=2.
REQ-005 clk_i  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 req_valid_i / req_ready_o  in/out  1/1  incoming sync request handshake.
REQ-008 req_level_i, req_id_i, req_sd_i  in  LEVEL_WIDTH/ID_WIDTH/SD_WIDTH  request fields.
REQ-009 level_o, id_o, sd_local_o  out  LEVEL_WIDTH/ID_WIDTH/SD_WIDTH  lookup fields driven to the RF.
REQ-010 check_local_o, check_remote_o  out  1 each  RF lookup strobes.
REQ-011 present_local_i, present_remote_i, id_err_i, sig_err_i, bypass_local_i, bypass_remote_i, ignore_local_i, ignore_remote_i  in  1 each  same-cycle RF response.
REQ-012 sd_local_i  in  SD_WIDTH  stored sources returned by the local RF.
REQ-013 up_valid_o / up_ready_i, up_level_o, up_id_o  out/in, 1/1, LEVEL_WIDTH, ID_WIDTH  request forwarded to the parent node.
REQ-014 down_valid_o / down_ready_i, down_id_o, down_sd_o  out/in, 1/1, ID_WIDTH, SD_WIDTH  wake-up toward children.
REQ-015 err_o  out  1  one-cycle error pulse.

Function
REQ-016 The block SHALL implement FSM states IDLE, CHECK, UP, DOWN, with one registered request (level, id, sd, kind) and a FIFO_DEPTH-entry bypass FIFO.
REQ-017 Kind: level==0 is LOCAL; any other level is REMOTE.
REQ-018 IDLE: if the FIFO is non-empty, the FSM SHALL pop the head into the request register and go to CHECK; FIFO entries take priority over new requests.
REQ-019 IDLE: if the FIFO is empty, the block SHALL assert req_ready_o; on req_valid_i&&req_ready_o it SHALL capture the fields and go to CHECK.
REQ-020 req_ready_o SHALL be 0 in every state other than IDLE, and in IDLE whenever the FIFO is non-empty or full.
REQ-021 CHECK SHALL last exactly one cycle and assert exactly one strobe (check_local_o for LOCAL, check_remote_o for REMOTE), with level_o, id_o and sd_local_o taken from the request register.
REQ-022 In CHECK the RF response SHALL be resolved in the priority order listed in REQ-023 to REQ-029.
REQ-023 First: id_err_i (LOCAL) or sig_err_i (REMOTE) SHALL pulse err_o for 1 cycle, drop the request and go to IDLE.
REQ-024 Second: ignore_* SHALL drop the request and go to IDLE.
REQ-025 Third: bypass_* SHALL push the request into the FIFO and go to IDLE.
REQ-026 LOCAL with present_local_i SHALL load down_sd_o = sd_local_i | request sd and down_id_o = id, then go to DOWN.
REQ-027 LOCAL without present_local_i SHALL go to IDLE; the RF has stored the request.
REQ-028 REMOTE without present_remote_i SHALL load up_level_o = level-1 and up_id_o = id, then go to UP.
REQ-029 REMOTE with present_remote_i SHALL go to IDLE; the request is absorbed.
REQ-030 UP SHALL hold up_valid_o=1 with stable fields until up_ready_i, then go to IDLE; DOWN behaves the same way with down_valid_o / down_ready_i.
REQ-031 A bypass push SHALL never find the FIFO full, because CHECK is entered only when the FIFO has at least one free slot; a popped entry frees its slot.
REQ-032 The FIFO SHALL use wrap-around pointers plus a count of width $clog2(FIFO_DEPTH)+1.
REQ-033 A push in CHECK and a pop in IDLE never occur in the same cycle.
REQ-034 With the FIFO empty and no request, IDLE SHALL hold and drive all strobes to 0.

Reset
REQ-035 On rst_i, asynchronously and regardless of state, the block SHALL set the state to IDLE and clear the FIFO pointers and count.
REQ-036 On rst_i, all valid, strobe and err outputs and the request register SHALL go to 0; a request in flight is discarded.
REQ-037 After rst_i deasserts, req_ready_o SHALL be 1 on the first clock edge.

Verification
REQ-038 LOCAL id=1 sd=01, RF not present -> check_local_o for 1 cycle, no down_valid_o, back to IDLE.
REQ-039 LOCAL id=1 sd=10, present_local_i=1, sd_local_i=01 -> down_valid_o with down_sd_o=11, id=1, held 3 cycles until down_ready_i.
REQ-040 REMOTE level=2 id=0, RF not present -> up_valid_o with up_level_o=1; a second identical request with present_remote_i=1 -> absorbed, no up_valid_o.
REQ-041 bypass_local_i on 4 consecutive requests (FIFO_DEPTH=4) -> req_ready_o=0 while the FIFO is non-empty; entries re-checked in FIFO order.
REQ-042 sig_err_i=1 on REMOTE check -> err_o pulses 1 cycle, no up_valid_o.
REQ-043 rst_i asserted mid-UP with FIFO count 2 -> up_valid_o=0 immediately, count 0, req_ready_o=1 after release.

Source files
------------

// File: rtl/fractal_sync_1d_rf_req_ctrl_if.sv
// ----------------------------------------------------------------------------
// fractal_sync_1d_rf_req_ctrl_if
//   Bundles every non-clock/reset signal of the 1D fractal-sync RF request
//   controller. Signal suffixes (_i/_o) are written from the controller's
//   point of view.
//
//   Groups:
//     req_*                 incoming sync request (valid/ready + fields)
//     level_o/id_o/...      RF lookup fields and strobes
//     present_*/..._i       same-cycle RF response
//     up_*                  request forwarded to the parent node
//     down_*                wake-up toward the children
//     err_o                 one-cycle error pulse
//
//   Modports:
//     slave  - the controller
//     master - the environment (requester, RF, parent, children)
// ----------------------------------------------------------------------------
interface fractal_sync_1d_rf_req_ctrl_if #(
    parameter int unsigned LEVEL_WIDTH = 1,
    parameter int unsigned ID_WIDTH    = 1,
    parameter int unsigned SD_WIDTH    = 2
);
    // request handshake
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [LEVEL_WIDTH-1:0] req_level_i;
    logic [ID_WIDTH-1:0]    req_id_i;
    logic [SD_WIDTH-1:0]    req_sd_i;

    // RF lookup
    logic [LEVEL_WIDTH-1:0] level_o;
    logic [ID_WIDTH-1:0]    id_o;
    logic [SD_WIDTH-1:0]    sd_local_o;
    logic                   check_local_o;
    logic                   check_remote_o;

    // RF response
    logic                   present_local_i;
    logic                   present_remote_i;
    logic                   id_err_i;
    logic                   sig_err_i;
    logic                   bypass_local_i;
    logic                   bypass_remote_i;
    logic                   ignore_local_i;
    logic                   ignore_remote_i;
    logic [SD_WIDTH-1:0]    sd_local_i;

    // toward parent
    logic                   up_valid_o;
    logic                   up_ready_i;
    logic [LEVEL_WIDTH-1:0] up_level_o;
    logic [ID_WIDTH-1:0]    up_id_o;

    // toward children
    logic                   down_valid_o;
    logic                   down_ready_i;
    logic [ID_WIDTH-1:0]    down_id_o;
    logic [SD_WIDTH-1:0]    down_sd_o;

    logic                   err_o;

    modport slave (
        input  req_valid_i, req_level_i, req_id_i, req_sd_i,
        output req_ready_o,
        output level_o, id_o, sd_local_o, check_local_o, check_remote_o,
        input  present_local_i, present_remote_i, id_err_i, sig_err_i,
        input  bypass_local_i, bypass_remote_i, ignore_local_i, ignore_remote_i,
        input  sd_local_i,
        output up_valid_o, up_level_o, up_id_o,
        input  up_ready_i,
        output down_valid_o, down_id_o, down_sd_o,
        input  down_ready_i,
        output err_o
    );

    modport master (
        output req_valid_i, req_level_i, req_id_i, req_sd_i,
        input  req_ready_o,
        input  level_o, id_o, sd_local_o, check_local_o, check_remote_o,
        output present_local_i, present_remote_i, id_err_i, sig_err_i,
        output bypass_local_i, bypass_remote_i, ignore_local_i, ignore_remote_i,
        output sd_local_i,
        input  up_valid_o, up_level_o, up_id_o,
        output up_ready_i,
        input  down_valid_o, down_id_o, down_sd_o,
        output down_ready_i,
        input  err_o
    );
endinterface

// File: rtl/fractal_sync_1d_rf_req_ctrl.sv
// ----------------------------------------------------------------------------
// fractal_sync_1d_rf_req_ctrl
//   Request controller for one node of a 1D fractal-sync tree. Each request
//   (level, id, sd) is checked against the register file for one cycle; the
//   RF response decides whether it is dropped, stored, deferred through a
//   small bypass FIFO, forwarded to the parent (UP) or turned into a wake-up
//   for the children (DOWN). Level 0 requests are LOCAL, all others REMOTE.
//
//   Ports:
//     clk_i  - clock, rising edge
//     rst_i  - asynchronous, active-high reset
//     bus    - fractal_sync_1d_rf_req_ctrl_if.slave (request, RF lookup and
//              response, up/down handshakes, err pulse)
// ----------------------------------------------------------------------------
module fractal_sync_1d_rf_req_ctrl #(
    parameter int unsigned LEVEL_WIDTH = 1,
    parameter int unsigned ID_WIDTH    = 1,
    parameter int unsigned SD_WIDTH    = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    fractal_sync_1d_rf_req_ctrl_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } state_e;

    typedef struct packed {
        logic [LEVEL_WIDTH-1:0] level;
        logic [ID_WIDTH-1:0]    id;
        logic [SD_WIDTH-1:0]    sd;
    } req_t;

    state_e state_q, state_d;

    // request register; kind is kept explicitly (1 = REMOTE)
    req_t req_q;
    logic req_remote_q;

    // bypass FIFO
    req_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] fifo_cnt_q;
    logic             fifo_empty;

    // forwarded request / wake-up registers
    logic [LEVEL_WIDTH-1:0] up_level_q;
    logic [ID_WIDTH-1:0]    up_id_q;
    logic [ID_WIDTH-1:0]    down_id_q;
    logic [SD_WIDTH-1:0]    down_sd_q;

    // decode strobes
    logic push, pop, load_req, load_up, load_down;
    logic req_ready, check_local, check_remote, err;

    assign fifo_empty = (fifo_cnt_q == '0);

    // ------------------------------------------------------------------
    // Next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        push         = 1'b0;
        pop          = 1'b0;
        load_req     = 1'b0;
        load_up      = 1'b0;
        load_down    = 1'b0;
        req_ready    = 1'b0;
        check_local  = 1'b0;
        check_remote = 1'b0;
        err          = 1'b0;

        unique case (state_q)
            IDLE: begin
                // deferred requests are re-checked before any new request
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = CHECK;
                end else begin
                    req_ready = 1'b1;
                    if (bus.req_valid_i) begin
                        load_req = 1'b1;
                        state_d  = CHECK;
                    end
                end
            end

            CHECK: begin
                // CHECK is always entered with at least one free FIFO slot:
                // either the FIFO was empty or this request was just popped.
                state_d = IDLE;
                if (req_remote_q) begin
                    check_remote = 1'b1;
                    if (bus.sig_err_i) begin
                        err = 1'b1;
                    end else if (bus.ignore_remote_i) begin
                        // dropped
                    end else if (bus.bypass_remote_i) begin
                        push = 1'b1;
                    end else if (!bus.present_remote_i) begin
                        load_up = 1'b1;
                        state_d = UP;
                    end
                end else begin
                    check_local = 1'b1;
                    if (bus.id_err_i) begin
                        err = 1'b1;
                    end else if (bus.ignore_local_i) begin
                        // dropped
                    end else if (bus.bypass_local_i) begin
                        push = 1'b1;
                    end else if (bus.present_local_i) begin
                        load_down = 1'b1;
                        state_d   = DOWN;
                    end
                end
            end

            UP:   if (bus.up_ready_i)   state_d = IDLE;
            DOWN: if (bus.down_ready_i) state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Request register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q        <= '0;
            req_remote_q <= 1'b0;
        end else if (load_req) begin
            req_q.level  <= bus.req_level_i;
            req_q.id     <= bus.req_id_i;
            req_q.sd     <= bus.req_sd_i;
            req_remote_q <= |bus.req_level_i;
        end else if (pop) begin
            req_q        <= fifo_mem[rd_ptr_q];
            req_remote_q <= |fifo_mem[rd_ptr_q].level;
        end
    end

    // ------------------------------------------------------------------
    // Bypass FIFO: storage is not reset, only pointers and count.
    // Push (CHECK) and pop (IDLE) are mutually exclusive by state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= req_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push)     fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            else if (pop) fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Up / down payload registers, held stable for the whole handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            up_level_q <= '0;
            up_id_q    <= '0;
            down_id_q  <= '0;
            down_sd_q  <= '0;
        end else begin
            if (load_up) begin
                up_level_q <= req_q.level - LEVEL_WIDTH'(1);
                up_id_q    <= req_q.id;
            end
            if (load_down) begin
                // wake every child that has arrived so far plus the requester
                down_id_q <= req_q.id;
                down_sd_q <= bus.sd_local_i | req_q.sd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready_o    = req_ready;
    assign bus.level_o        = req_q.level;
    assign bus.id_o           = req_q.id;
    assign bus.sd_local_o     = req_q.sd;
    assign bus.check_local_o  = check_local;
    assign bus.check_remote_o = check_remote;
    assign bus.up_valid_o     = (state_q == UP);
    assign bus.up_level_o     = up_level_q;
    assign bus.up_id_o        = up_id_q;
    assign bus.down_valid_o   = (state_q == DOWN);
    assign bus.down_id_o      = down_id_q;
    assign bus.down_sd_o      = down_sd_q;
    assign bus.err_o          = err;

endmodule

// File: tb/tb_fractal_sync_1d_rf_req_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fractal_sync_1d_rf_req_ctrl
//   Directed scenarios with literal expectations, then randomized traffic,
//   all cross-checked every cycle against a transaction-level model built
//   from a queue (bypass FIFO) and the current request.
// ----------------------------------------------------------------------------
module tb_fractal_sync_1d_rf_req_ctrl;

    localparam int LW = 2;
    localparam int IW = 1;
    localparam int SW = 2;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fractal_sync_1d_rf_req_ctrl_if #(.LEVEL_WIDTH(LW), .ID_WIDTH(IW), .SD_WIDTH(SW)) bus ();

    fractal_sync_1d_rf_req_ctrl #(
        .LEVEL_WIDTH(LW), .ID_WIDTH(IW), .SD_WIDTH(SW), .FIFO_DEPTH(FD)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef enum int {M_IDLE, M_CHECK, M_UP, M_DOWN} mode_t;
    typedef struct {
        int level;
        int id;
        int sd;
    } mreq_t;

    mode_t mode;
    mreq_t mq[$];
    mreq_t cur;
    int    m_up_level, m_up_id, m_down_id, m_down_sd;

    task automatic model_reset();
        mode = M_IDLE;
        mq.delete();
        cur = '{0, 0, 0};
        m_up_level = 0; m_up_id = 0; m_down_id = 0; m_down_sd = 0;
    endtask

    // Compare DUT against the model for the current cycle, then advance the
    // model by the rising edge that follows (inputs are stable until then).
    task automatic eval_cycle();
        bit loc, e;
        #1;
        if (rst) model_reset();
        loc = (cur.level == 0);
        e   = (mode == M_CHECK) && (loc ? bus.id_err_i : bus.sig_err_i);
        chk("req_ready",    32'(bus.req_ready_o),    32'(mode == M_IDLE && mq.size() == 0));
        chk("check_local",  32'(bus.check_local_o),  32'(mode == M_CHECK && loc));
        chk("check_remote", 32'(bus.check_remote_o), 32'(mode == M_CHECK && !loc));
        chk("up_valid",     32'(bus.up_valid_o),     32'(mode == M_UP));
        chk("down_valid",   32'(bus.down_valid_o),   32'(mode == M_DOWN));
        chk("err",          32'(bus.err_o),          32'(e));
        if (mode == M_CHECK) begin
            chk("level_o",    32'(bus.level_o),    32'(cur.level));
            chk("id_o",       32'(bus.id_o),       32'(cur.id));
            chk("sd_local_o", 32'(bus.sd_local_o), 32'(cur.sd));
        end
        if (mode == M_UP) begin
            chk("up_level", 32'(bus.up_level_o), 32'(m_up_level));
            chk("up_id",    32'(bus.up_id_o),    32'(m_up_id));
        end
        if (mode == M_DOWN) begin
            chk("down_id", 32'(bus.down_id_o), 32'(m_down_id));
            chk("down_sd", 32'(bus.down_sd_o), 32'(m_down_sd));
        end
        if (rst) return;
        case (mode)
            M_IDLE: begin
                if (mq.size() != 0) begin
                    cur  = mq.pop_front();
                    mode = M_CHECK;
                end else if (bus.req_valid_i) begin
                    cur  = '{int'(bus.req_level_i), int'(bus.req_id_i), int'(bus.req_sd_i)};
                    mode = M_CHECK;
                end
            end
            M_CHECK: begin
                mode = M_IDLE;
                if (loc) begin
                    if (bus.id_err_i || bus.ignore_local_i) ;
                    else if (bus.bypass_local_i) mq.push_back(cur);
                    else if (bus.present_local_i) begin
                        m_down_id = cur.id;
                        m_down_sd = int'(bus.sd_local_i) | cur.sd;
                        mode = M_DOWN;
                    end
                end else begin
                    if (bus.sig_err_i || bus.ignore_remote_i) ;
                    else if (bus.bypass_remote_i) mq.push_back(cur);
                    else if (!bus.present_remote_i) begin
                        m_up_level = (cur.level - 1) % (1 << LW);
                        m_up_id    = cur.id;
                        mode = M_UP;
                    end
                end
            end
            M_UP:   if (bus.up_ready_i)   mode = M_IDLE;
            M_DOWN: if (bus.down_ready_i) mode = M_IDLE;
            default: mode = M_IDLE;
        endcase
    endtask

    task automatic tick();
        eval_cycle();
        @(negedge clk);
    endtask

    task automatic clear_in();
        bus.req_valid_i = 1'b0; bus.req_level_i = '0; bus.req_id_i = '0; bus.req_sd_i = '0;
        bus.present_local_i = 1'b0; bus.present_remote_i = 1'b0;
        bus.id_err_i = 1'b0; bus.sig_err_i = 1'b0;
        bus.bypass_local_i = 1'b0; bus.bypass_remote_i = 1'b0;
        bus.ignore_local_i = 1'b0; bus.ignore_remote_i = 1'b0;
        bus.sd_local_i = '0; bus.up_ready_i = 1'b0; bus.down_ready_i = 1'b0;
    endtask

    // Present one request for one cycle (DUT is known idle), leaves the bus
    // at negedge of the CHECK cycle.
    task automatic send(input int lvl, input int id, input int sd);
        bus.req_valid_i = 1'b1;
        bus.req_level_i = LW'(lvl); bus.req_id_i = IW'(id); bus.req_sd_i = SW'(sd);
        eval_cycle();
        chk("send_ready", 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_in();
        @(negedge clk);

        // reset state
        eval_cycle();
        chk("rst_up_valid",   32'(bus.up_valid_o),    32'd0);
        chk("rst_down_valid", 32'(bus.down_valid_o),  32'd0);
        chk("rst_err",        32'(bus.err_o),         32'd0);
        chk("rst_check",      32'(bus.check_local_o | bus.check_remote_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        eval_cycle();
        chk("post_rst_ready", 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);

        // LOCAL, RF not present: one CHECK cycle, no wake-up
        send(0, 1, 1);
        eval_cycle();
        chk("t038_check_local", 32'(bus.check_local_o), 32'd1);
        chk("t038_id_o",        32'(bus.id_o),          32'd1);
        chk("t038_sd_o",        32'(bus.sd_local_o),    32'd1);
        @(negedge clk);
        eval_cycle();
        chk("t038_strobe_off", 32'(bus.check_local_o), 32'd0);
        chk("t038_no_down",    32'(bus.down_valid_o),  32'd0);
        @(negedge clk);

        // LOCAL present: down_sd = 01 | 10, held while down_ready is low
        bus.present_local_i = 1'b1; bus.sd_local_i = 2'b01;
        send(0, 1, 2);
        tick();
        for (int i = 0; i < 3; i++) begin
            eval_cycle();
            chk("t039_down_valid", 32'(bus.down_valid_o), 32'd1);
            chk("t039_down_sd",    32'(bus.down_sd_o),    32'd3);
            chk("t039_down_id",    32'(bus.down_id_o),    32'd1);
            @(negedge clk);
        end
        bus.down_ready_i = 1'b1;
        tick();
        clear_in();
        eval_cycle();
        chk("t039_down_done", 32'(bus.down_valid_o), 32'd0);
        @(negedge clk);

        // REMOTE level 2 not present -> UP with level 1; then absorbed
        send(2, 0, 0);
        eval_cycle();
        chk("t040_check_remote", 32'(bus.check_remote_o), 32'd1);
        @(negedge clk);
        bus.up_ready_i = 1'b1;
        eval_cycle();
        chk("t040_up_valid", 32'(bus.up_valid_o), 32'd1);
        chk("t040_up_level", 32'(bus.up_level_o), 32'd1);
        chk("t040_up_id",    32'(bus.up_id_o),    32'd0);
        @(negedge clk);
        bus.up_ready_i = 1'b0; bus.present_remote_i = 1'b1;
        send(2, 0, 0);
        tick();
        eval_cycle();
        chk("t040_absorbed", 32'(bus.up_valid_o), 32'd0);
        @(negedge clk);
        clear_in();

        // bypass: request deferred, ready low while queued, re-checked intact
        for (int k = 0; k < 4; k++) begin
            bus.bypass_local_i = 1'b1;
            send(0, k & 1, k);
            tick();
            bus.bypass_local_i = 1'b0;
            eval_cycle();
            chk("t041_ready_low", 32'(bus.req_ready_o), 32'd0);
            @(negedge clk);
            eval_cycle();
            chk("t041_recheck", 32'(bus.check_local_o), 32'd1);
            chk("t041_sd",      32'(bus.sd_local_o),    32'(k));
            @(negedge clk);
            tick();
        end

        // sig_err on REMOTE: single err pulse, no UP
        bus.sig_err_i = 1'b1;
        send(1, 1, 0);
        eval_cycle();
        chk("t042_err", 32'(bus.err_o), 32'd1);
        @(negedge clk);
        eval_cycle();
        chk("t042_err_off", 32'(bus.err_o),      32'd0);
        chk("t042_no_up",   32'(bus.up_valid_o), 32'd0);
        @(negedge clk);
        clear_in();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid_i      = 1'($urandom_range(0, 1));
            bus.req_level_i      = $urandom_range(0, 1) ? '0 : LW'($urandom_range(1, 3));
            bus.req_id_i         = IW'($urandom);
            bus.req_sd_i         = SW'($urandom);
            bus.id_err_i         = ($urandom_range(0, 9) == 0);
            bus.sig_err_i        = ($urandom_range(0, 9) == 0);
            bus.ignore_local_i   = ($urandom_range(0, 9) == 0);
            bus.ignore_remote_i  = ($urandom_range(0, 9) == 0);
            bus.bypass_local_i   = ($urandom_range(0, 4) == 0);
            bus.bypass_remote_i  = ($urandom_range(0, 4) == 0);
            bus.present_local_i  = 1'($urandom_range(0, 1));
            bus.present_remote_i = 1'($urandom_range(0, 1));
            bus.sd_local_i       = SW'($urandom);
            bus.up_ready_i       = ($urandom_range(0, 2) == 0);
            bus.down_ready_i     = ($urandom_range(0, 2) == 0);
            rst                  = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        clear_in();
        bus.up_ready_i = 1'b1; bus.down_ready_i = 1'b1;
        begin
            int n = 0;
            while (!(mode == M_IDLE && mq.size() == 0) && n < 50) begin
                tick();
                n++;
            end
            if (n == 50) chk("drain_timeout", 32'd1, 32'd0);
        end
        clear_in();

        // reset in the middle of an UP handshake
        send(1, 1, 0);
        tick();
        eval_cycle();
        chk("t043_in_up", 32'(bus.up_valid_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        eval_cycle();
        chk("t043_up_cleared", 32'(bus.up_valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        eval_cycle();
        chk("t043_ready_after", 32'(bus.req_ready_o), 32'd1);
        chk("t043_still_idle",  32'(bus.up_valid_o),  32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
